// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Odd-parity enforcement is selected with the PS2_PARITY_CHECK_EN macro.
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;
    localparam int CNT_W      = $clog2(DATA_BITS);

    // Scan-code prefixes used by the downstream decoder.
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Debug view of the receiver, exported on the bus for checkers.
    typedef struct packed {
        ps2_state_e       state;
        logic [CNT_W-1:0] bit_cnt;
        logic             parity_ok;
    } ps2_dbg_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_if.sv
// Pin-side bus of the PS/2 receiver: serial data in, byte history and
// status pulses out. There is no valid/ready handshake here: data_in is a
// free-running line sampled every clk edge, and data_valid / frame_err are
// single-cycle strobes that the consumer cannot back-pressure.
interface ps2_if #(
    parameter int HIST_BYTES = 2
) ();
    import ps2_pkg::*;

    logic                    data_in;
    logic [8*HIST_BYTES-1:0] data_out;
    logic                    data_valid;
    logic                    frame_err;
    ps2_dbg_t                dbg;

    modport master (
        output data_in,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  dbg
    );

    modport slave (
        input  data_in,
        output data_out,
        output data_valid,
        output frame_err,
        output dbg
    );

endinterface

// File: rtl/ps2.sv
// PS/2 keyboard frame receiver clocked directly by the keyboard clock line.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2
    import ps2_pkg::*;
#(
    parameter int HIST_BYTES = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    ps2_if.slave  ps2_bus
);

    localparam int HW = 8 * HIST_BYTES;

    ps2_state_e           state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 par_bit_q, par_bit_d;
    logic [HW-1:0]        data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 err_q,     err_d;

    logic sample;
    logic parity_ok;
    logic frame_good;

    assign sample    = ps2_bus.data_in;
    assign parity_ok = par_acc_q ^ par_bit_q;

    // The stop bit is the live sample; parity was captured one edge earlier.
`ifdef PS2_PARITY_CHECK_EN
    assign frame_good = sample & parity_ok;
`else
    assign frame_good = sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_acc_q <= par_acc_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!sample) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    shift_d   = '0;
                    par_acc_d = 1'b0;
                end
            end
            DATA: begin
                shift_d[cnt_q] = sample;
                par_acc_d      = par_acc_q ^ sample;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                par_bit_d = sample;
                state_d   = STOP;
            end
            STOP: begin
                // Newest byte enters at the bottom; the oldest falls off the top.
                if (frame_good) begin
                    data_d  = (data_q << DATA_BITS) | HW'(shift_q);
                    valid_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ps2_bus.data_out   = data_q;
    assign ps2_bus.data_valid = valid_q;
    assign ps2_bus.frame_err  = err_q;
    assign ps2_bus.dbg        = '{state: state_q, bit_cnt: cnt_q, parity_ok: parity_ok};

endmodule

// File: tb/tb_ps2.sv
// Directed plus randomized bench for the PS/2 receiver against a byte-history model.
module tb_ps2;
    import ps2_pkg::*;

    localparam int HIST = 2;
    localparam int W    = 8 * HIST;

    logic clk;
    logic rst_n;

    ps2_if #(.HIST_BYTES(HIST)) bus ();

    ps2 #(.HIST_BYTES(HIST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int exp_valid_cnt = 0;
    int exp_err_cnt   = 0;
    int seen_valid    = 0;
    int seen_err      = 0;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) seen_valid++;
        if (bus.frame_err  === 1'b1) seen_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // History word: newest byte at [7:0], older bytes above it, zeros if absent.
    function automatic logic [W-1:0] exp_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < HIST; i++) begin
            if (i < exp_q.size()) w[8*i +: 8] = exp_q[exp_q.size() - 1 - i];
        end
        return w;
    endfunction

    function automatic logic model_good(input logic [7:0] data, input logic par, input logic stop);
        logic par_ok;
        par_ok = ((($countones(data) + int'(par)) % 2) == 1);
`ifdef PS2_PARITY_CHECK_EN
        return stop && par_ok;
`else
        if (par_ok) return stop;
        return stop;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Data changes at a falling edge; the following rising edge samples it,
    // and the task returns at the next falling edge where outputs are checked.
    task automatic send_bit(input logic b);
        bus.data_in = b;
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid_low"}, {31'd0, bus.data_valid}, 32'd0);
        check({tag, "_err_low"},   {31'd0, bus.frame_err},  32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'b1);
            check_quiet("idle");
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        logic good;
        send_bit(1'b0);
        check_quiet("start");
        for (int i = 0; i < DATA_BITS; i++) begin
            send_bit(data[i]);
            check_quiet("data_bit");
        end
        send_bit(par);
        check_quiet("parity_bit");
        send_bit(stop);
        good = model_good(data, par, stop);
        if (good) begin
            exp_q.push_back(data);
            exp_valid_cnt++;
        end else begin
            exp_err_cnt++;
        end
        check("frame_data_out",   {{(32-W){1'b0}}, bus.data_out}, {{(32-W){1'b0}}, exp_word()});
        check("frame_data_valid", {31'd0, bus.data_valid}, {31'd0, good});
        check("frame_frame_err",  {31'd0, bus.frame_err},  {31'd0, !good});
    endtask

    task automatic do_reset();
        bus.data_in = 1'b1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("reset_data_out", {{(32-W){1'b0}}, bus.data_out}, 32'd0);
        check_quiet("reset");
        rst_n = 1'b1;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;
        logic       rp;
        logic       rs;

        rst_n = 1'b0;
        bus.data_in = 1'b1;
        @(negedge clk);
        do_reset();

        // Idle line: nothing happens.
        idle(20);
        check("idle_data_out", {{(32-W){1'b0}}, bus.data_out}, 32'd0);

        // Single frame right after reset.
        do_reset();
        send_frame(8'h1A, 1'b0, 1'b1);

        // Four frames back to back with no idle bits.
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(8'h1A, 1'b0, 1'b1);

        // Break prefix followed by a code.
        idle(2);
        send_frame(SC_BREAK, odd_par(SC_BREAK), 1'b1);
        send_frame(8'h1A, 1'b0, 1'b1);
        check("break_hist", {{(32-W){1'b0}}, bus.data_out}, 32'h0000F01A);

        // Bad stop bit, then a good frame immediately afterwards.
        send_frame(8'h1A, 1'b0, 1'b0);
        send_frame(8'h5C, odd_par(8'h5C), 1'b1);

        // Wrong parity: outcome depends on the build option.
        idle(1);
        send_frame(8'h1A, 1'b1, 1'b1);
        send_frame(SC_EXTEND, odd_par(SC_EXTEND), 1'b1);

        // Reset in the middle of a frame discards it.
        idle(3);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        bus.data_in = 1'b1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midreset_data_out", {{(32-W){1'b0}}, bus.data_out}, 32'd0);
        check_quiet("midreset");
        rst_n = 1'b1;
        send_frame(8'h33, odd_par(8'h33), 1'b1);

        // Randomized traffic with occasional bad parity / stop and idle gaps.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       rb = SC_BREAK;
                1:       rb = SC_EXTEND;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            rp = ($urandom_range(0, 3) == 0) ? ~odd_par(rb) : odd_par(rb);
            rs = ($urandom_range(0, 7) != 0);
            send_frame(rb, rp, rs);
            idle($urandom_range(0, 2));
        end

        idle(2);
        check("valid_pulse_count", seen_valid, exp_valid_cnt);
        check("err_pulse_count",   seen_err,   exp_err_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
